// File: rtl/uart_rx_engine_pkg.sv
// Shared definitions for the UART receive engine: states, baud table and bit-time math.
package uart_rx_engine_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_CHK = 2'd1,
        RECEIVE   = 2'd2,
        DONE      = 2'd3
    } rx_state_t;

    localparam int SR_W        = 10;
    localparam int DATA_BITS_8 = 8;
    localparam int DATA_BITS_7 = 7;
    localparam int N_BAUD_SEL  = 16;

    function automatic int baud_rate(input int sel);
        case (sel)
            0:       return 300;
            1:       return 1200;
            2:       return 2400;
            3:       return 4800;
            4:       return 9600;
            5:       return 19200;
            6:       return 38400;
            7:       return 57600;
            8:       return 115200;
            9:       return 230400;
            10:      return 460800;
            11:      return 921600;
            default: return 115200;
        endcase
    endfunction

    // Clocks per bit, rounded to nearest.
    function automatic int bit_ticks(input int clk_hz, input int sel);
        int rate;
        rate = baud_rate(sel);
        return (clk_hz + rate / 2) / rate;
    endfunction

    // Counter width sized by the slowest rate so a full bit never wraps.
    function automatic int tick_width(input int clk_hz);
        return $clog2(bit_ticks(clk_hz, 0) + 1);
    endfunction

endpackage

// File: rtl/rx_baud_timer.sv
// Loadable down-counter; tick is high for the single cycle the count sits at 1.
module rx_baud_timer #(
    parameter int CW = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          tick
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign tick = (cnt == CW'(1));

endmodule

// File: rtl/uart_rx_engine.sv
// UART receiver: synchronizer, frame FSM, shift register and host-visible status flags.
// state     | meaning
// IDLE      | waiting for a falling edge on the synchronized line
// START_CHK | half bit elapsed check that start bit is still low
// RECEIVE   | sampling data, parity and stop bits at mid-bit
// DONE      | one cycle: publish character and flags
module uart_rx_engine
    import uart_rx_engine_pkg::*;
#(
    parameter int CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx,
    input  logic [3:0] Baud_Val,
    input  logic       EIGHT,
    input  logic       PEN,
    input  logic       OHEL,
    input  logic       Read,
    output logic [7:0] Data,
    output logic       RxRdy,
    output logic       PERR,
    output logic       FERR,
    output logic       OVF
);

    localparam int CW = tick_width(CLK_HZ);

    logic [CW-1:0] tick_tbl [N_BAUD_SEL];

    for (genvar g = 0; g < N_BAUD_SEL; g++) begin : g_tick_tbl
        assign tick_tbl[g] = CW'(bit_ticks(CLK_HZ, g));
    end

    logic            rx_meta, rx_sync;
    rx_state_t       state;
    logic [3:0]      baud_q;
    logic            eight_q, pen_q, ohel_q;
    logic [3:0]      bit_idx;
    logic [SR_W-1:0] sh;
    logic            rx_high_seen;

    logic            tick;
    logic            timer_load;
    logic [CW-1:0]   timer_val;
    logic            start_det;
    logic [3:0]      n_samples;
    logic [3:0]      last_idx;
    logic [3:0]      shamt;
    logic [8:0]      aligned;
    logic [7:0]      data_nxt;
    logic            par_bit;
    logic            stop_bit;
    logic            perr_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
        end
    end

    // A line stuck low after a bad stop bit must go high before a new start is accepted.
    assign start_det = !rx_sync && rx_high_seen;

    assign n_samples = (eight_q ? 4'(DATA_BITS_8) : 4'(DATA_BITS_7)) + {3'b000, pen_q} + 4'd1;
    assign last_idx  = n_samples - 4'd1;
    assign shamt     = 4'(SR_W) - n_samples;
    assign aligned   = 9'(sh >> shamt);
    assign data_nxt  = eight_q ? aligned[7:0] : {1'b0, aligned[6:0]};
    assign par_bit   = eight_q ? aligned[8] : aligned[7];
    assign stop_bit  = sh[SR_W-1];
    assign perr_nxt  = pen_q & (^data_nxt ^ par_bit ^ ohel_q);

    always_comb begin
        timer_load = 1'b0;
        timer_val  = tick_tbl[baud_q];
        case (state)
            IDLE: begin
                if (start_det) begin
                    timer_load = 1'b1;
                    timer_val  = tick_tbl[Baud_Val] >> 1;
                end
            end
            START_CHK: timer_load = tick && !rx_sync;
            RECEIVE:   timer_load = tick && (bit_idx != last_idx);
            default:   timer_load = 1'b0;
        endcase
    end

    rx_baud_timer #(
        .CW(CW)
    ) u_baud_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            baud_q       <= '0;
            eight_q      <= 1'b0;
            pen_q        <= 1'b0;
            ohel_q       <= 1'b0;
            bit_idx      <= '0;
            sh           <= '0;
            rx_high_seen <= 1'b0;
            Data         <= '0;
            RxRdy        <= 1'b0;
            PERR         <= 1'b0;
            FERR         <= 1'b0;
            OVF          <= 1'b0;
        end else begin
            if (Read) begin
                RxRdy <= 1'b0;
                OVF   <= 1'b0;
            end

            if (state == DONE) begin
                rx_high_seen <= 1'b0;
            end else if (rx_sync) begin
                rx_high_seen <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_det) begin
                        state   <= START_CHK;
                        baud_q  <= Baud_Val;
                        eight_q <= EIGHT;
                        pen_q   <= PEN;
                        ohel_q  <= OHEL;
                    end
                end
                START_CHK: begin
                    if (tick) begin
                        if (!rx_sync) begin
                            state   <= RECEIVE;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RECEIVE: begin
                    if (tick) begin
                        sh <= {rx_sync, sh[SR_W-1:1]};
                        if (bit_idx == last_idx) begin
                            state <= DONE;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
                DONE: begin
                    // A Read in this same cycle consumed the old character, so no overrun.
                    Data  <= data_nxt;
                    RxRdy <= 1'b1;
                    PERR  <= perr_nxt;
                    FERR  <= !stop_bit;
                    OVF   <= RxRdy && !Read;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
